// File: rtl/snoop_memory_ctrl.sv
// Snooping memory controller: serialises cache-miss requests, broadcasts snoops and
// serves data from a dirty cache or memory. Define SNOOP_TIMEOUT_EN to bound COLLECT.
module snoop_memory_ctrl #(
  parameter int SNOOP_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [1:0]  req_proc,
  input  logic [1:0]  req_block,
  input  logic [4:0]  req_tag,
  input  logic [7:0]  req_data,
  output logic        snoop_valid,
  output logic [1:0]  snoop_op,
  output logic [1:0]  snoop_src,
  output logic [1:0]  snoop_block,
  output logic [4:0]  snoop_tag,
  input  logic [3:0]  snoop_resp_valid,
  input  logic [3:0]  snoop_hit,
  input  logic [3:0]  snoop_wb,
  input  logic [31:0] snoop_data,
  output logic        resp_valid,
  output logic [1:0]  resp_proc,
  output logic [7:0]  resp_data,
  output logic        resp_shared,
  output logic        resp_from_cache,
  output logic        resp_timeout,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, WB, SNOOP, COLLECT, MEM, RESP} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  op_reg, op_next, proc_reg, proc_next, block_reg, block_next;
  logic [4:0]  tag_reg, tag_next;
  logic [7:0]  wdata_reg, wdata_next;
  logic [3:0]  responded_reg, responded_next, hit_reg, hit_next, wb_reg, wb_next;
  logic [7:0]  rdata_reg, rdata_next;
  logic        shared_reg, shared_next, from_cache_reg, from_cache_next;
  logic        timeout_reg, timeout_next;
  logic [7:0]  wb_byte_reg [4];
  logic [7:0]  byte_now [4];
  logic [3:0]  proc_mask, rv_eff, responded_all, hit_all, wb_all;
  logic        all_done, timeout_hit;
  logic [7:0]  wb_sel_byte;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rd [128];

  genvar gi;

  // Memory cells power up holding their own address; reset deliberately leaves them alone.
  for (gi = 0; gi < 128; gi++) begin : g_mem
    logic [7:0] cell_reg = 8'(gi);
    always @(posedge clock) begin
      if (mem_we && mem_addr == 7'(gi)) cell_reg <= mem_wdata;
    end
    assign mem_rd[gi] = cell_reg;
  end

  assign proc_mask     = 4'b0001 << proc_reg;
  assign rv_eff        = snoop_resp_valid & ~proc_mask;
  assign responded_all = responded_reg | rv_eff;
  assign hit_all       = hit_reg | (snoop_hit & ~proc_mask);
  assign wb_all        = wb_reg | (snoop_wb & rv_eff);
  assign all_done      = (responded_all | proc_mask) == 4'hF;

  // Each responder's writeback byte is held until COLLECT ends, as responses may be staggered.
  for (gi = 0; gi < 4; gi++) begin : g_wb_byte
    assign byte_now[gi] = (snoop_wb[gi] && rv_eff[gi]) ? snoop_data[8*gi +: 8] : wb_byte_reg[gi];
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) wb_byte_reg[gi] <= '0;
      else if (state_reg == COLLECT) wb_byte_reg[gi] <= byte_now[gi];
    end
  end

  always_comb begin
    wb_sel_byte = '0;
    for (int i = 3; i >= 0; i--) begin
      if (wb_all[i]) wb_sel_byte = byte_now[i];
    end
  end

`ifdef SNOOP_TIMEOUT_EN
  localparam int CW = $clog2(SNOOP_TIMEOUT + 1);
  logic [CW-1:0] cnt_reg, cnt_next;
  assign cnt_next    = (state_reg == COLLECT) ? cnt_reg + 1'b1 : '0;
  assign timeout_hit = (cnt_reg == CW'(SNOOP_TIMEOUT - 1));
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_reg <= '0;
    else        cnt_reg <= cnt_next;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^SNOOP_TIMEOUT;
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    op_next         = op_reg;
    proc_next       = proc_reg;
    block_next      = block_reg;
    tag_next        = tag_reg;
    wdata_next      = wdata_reg;
    responded_next  = responded_reg;
    hit_next        = hit_reg;
    wb_next         = wb_reg;
    rdata_next      = rdata_reg;
    shared_next     = shared_reg;
    from_cache_next = from_cache_reg;
    timeout_next    = timeout_reg;
    mem_we          = 1'b0;
    mem_addr        = {tag_reg, block_reg};
    mem_wdata       = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          op_next         = req_op;
          proc_next       = req_proc;
          block_next      = req_block;
          tag_next        = req_tag;
          wdata_next      = req_data;
          responded_next  = '0;
          hit_next        = '0;
          wb_next         = '0;
          rdata_next      = '0;
          shared_next     = 1'b0;
          from_cache_next = 1'b0;
          timeout_next    = 1'b0;
          state_next      = (req_op == 2'b00) ? WB : SNOOP;
        end
      end
      WB: begin
        mem_we     = 1'b1;
        state_next = RESP;
      end
      SNOOP: state_next = COLLECT;
      COLLECT: begin
        responded_next = responded_all;
        hit_next       = hit_all;
        wb_next        = wb_all;
        shared_next    = |hit_all;
        if (all_done) begin
          // A dirty copy supersedes memory for misses; invalidates never touch memory.
          if (op_reg != 2'b11 && |wb_all) begin
            mem_we          = 1'b1;
            mem_wdata       = wb_sel_byte;
            rdata_next      = wb_sel_byte;
            from_cache_next = 1'b1;
            state_next      = RESP;
          end else if (op_reg == 2'b11) begin
            state_next = RESP;
          end else begin
            state_next = MEM;
          end
        end else if (timeout_hit) begin
          timeout_next = 1'b1;
          state_next   = RESP;
        end
      end
      MEM: begin
        rdata_next = mem_rd[mem_addr];
        state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      op_reg         <= '0;
      proc_reg       <= '0;
      block_reg      <= '0;
      tag_reg        <= '0;
      wdata_reg      <= '0;
      responded_reg  <= '0;
      hit_reg        <= '0;
      wb_reg         <= '0;
      rdata_reg      <= '0;
      shared_reg     <= 1'b0;
      from_cache_reg <= 1'b0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      op_reg         <= op_next;
      proc_reg       <= proc_next;
      block_reg      <= block_next;
      tag_reg        <= tag_next;
      wdata_reg      <= wdata_next;
      responded_reg  <= responded_next;
      hit_reg        <= hit_next;
      wb_reg         <= wb_next;
      rdata_reg      <= rdata_next;
      shared_reg     <= shared_next;
      from_cache_reg <= from_cache_next;
      timeout_reg    <= timeout_next;
    end
  end

  assign req_ready       = (state_reg == IDLE);
  assign busy            = (state_reg != IDLE);
  assign snoop_valid     = (state_reg == SNOOP);
  assign snoop_op        = snoop_valid ? op_reg : '0;
  assign snoop_src       = snoop_valid ? proc_reg : '0;
  assign snoop_block     = snoop_valid ? block_reg : '0;
  assign snoop_tag       = snoop_valid ? tag_reg : '0;
  assign resp_valid      = (state_reg == RESP);
  assign resp_proc       = resp_valid ? proc_reg : '0;
  assign resp_data       = resp_valid ? rdata_reg : '0;
  assign resp_shared     = resp_valid & shared_reg;
  assign resp_from_cache = resp_valid & from_cache_reg;
  assign resp_timeout    = resp_valid & timeout_reg;

endmodule

// File: doc/snoop_memory_ctrl.md
SNOOP_MEMORY_CTRL -- requirements
Module: snoop_memory_ctrl

Interface
REQ-001 SHALL have parameter SNOOP_TIMEOUT, default 15, the maximum number of COLLECT cycles spent waiting for snoop responses.
REQ-002 SHALL have ports: clock  in  1  single clock, rising edge.
REQ-003 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: req_valid in 1 / req_ready out 1 / req_op in 2 (00 writeback, 01 read miss, 10 write miss, 11 invalidate) / req_proc in 2 / req_block in 2 / req_tag in 5 / req_data in 8 (writeback data).
REQ-005 SHALL have ports: snoop_valid out 1 / snoop_op out 2 / snoop_src out 2 / snoop_block out 2 / snoop_tag out 5, broadcast to all nodes.
REQ-006 SHALL have ports: snoop_resp_valid in 4 / snoop_hit in 4 / snoop_wb in 4 / snoop_data in 32; bit i or byte i belongs to processor i.
REQ-007 SHALL have ports: resp_valid out 1 / resp_proc out 2 / resp_data out 8 / resp_shared out 1 / resp_from_cache out 1 / resp_timeout out 1 / busy out 1.

Function
REQ-008 SHALL hold 128x8 memory addressed {tag,block}, with initial contents mem[a]=a; memory SHALL NOT be cleared by reset.
REQ-009 SHALL use FSM states IDLE, WB, SNOOP, COLLECT, MEM, RESP; req_ready=1 only in IDLE; busy=1 in every state except IDLE.
REQ-010 SHALL accept a request on a rising edge with req_valid&&req_ready and latch op, proc, block, tag and data; req_valid outside IDLE SHALL be ignored.
REQ-011 SHALL handle writeback (op 00) as IDLE->WB->RESP: the memory write occurs at the WB exit edge, with no snoop broadcast.
REQ-012 For ops 01/10/11, SHALL drive snoop_valid=1 for exactly the single SNOOP cycle, with the latched fields on snoop_*; snoop_* SHALL be 0 otherwise.
REQ-013 In COLLECT, SHALL accumulate responded|=snoop_resp_valid and hit|=snoop_hit, ignoring bit req_proc; COLLECT SHALL exit on the edge where all three other processors have responded.
REQ-014 If any responder asserted snoop_wb: SHALL select the lowest-index such processor, write its snoop_data byte to mem at COLLECT exit, set resp_from_cache=1, skip MEM (memory read aborted) and go to RESP with that byte as data.
REQ-015 Read/write miss with no wb: SHALL go COLLECT->MEM->RESP, reading mem registered in MEM; resp_from_cache=0.
REQ-016 Invalidate: SHALL go COLLECT->RESP with resp_data=0 and no memory access.
REQ-017 In RESP, SHALL assert resp_valid=1 for exactly one cycle with resp_proc=latched proc and resp_shared=accumulated hit (0 for writeback), then return to IDLE.
REQ-018 Latency from the accept edge to resp_valid SHALL be: writeback 2 cycles, invalidate or cache-supplied 3 cycles, memory-supplied 4 cycles (when all responses arrive in the first COLLECT cycle).
REQ-019 Same-cycle snoop_wb and snoop_hit from different processors SHALL both be honoured (shared=1, data from the wb source).
REQ-020 resp_data, resp_shared, resp_from_cache and resp_timeout SHALL be 0 whenever resp_valid=0.

Reset
REQ-021 reset=0 SHALL immediately force IDLE, clear latched request and accumulators, and set all outputs to 0 except req_ready=1.
REQ-022 Reset asserted mid-transaction SHALL abandon it without a memory write not yet committed and without resp_valid; the first request after release SHALL be accepted normally.

Configuration
REQ-023 With macro SNOOP_TIMEOUT_EN defined, a counter SHALL force COLLECT->RESP after SNOOP_TIMEOUT cycles, with resp_timeout=1, resp_data=0 and no memory access; without it, COLLECT SHALL wait indefinitely and resp_timeout SHALL be constant 0.

Verification
REQ-024 Read miss (proc1, block 2, tag 5), all others respond hit=0, wb=0 -> resp_valid 4 cycles after accept, resp_proc=1, resp_data=22, shared=0, from_cache=0.
REQ-025 Read miss (proc0, block 1, tag 3); proc2 responds wb=1, hit=1, data 0xAB -> resp_data=0xAB, shared=1, from_cache=1 at 3 cycles; a later read of the same address returns 0xAB from memory.
REQ-026 Writeback (proc3, block 0, tag 1, data 0x5C) -> resp_valid at 2 cycles, no snoop_valid; a subsequent read miss of address 4 returns 0x5C.
REQ-027 Invalidate from proc2 while req_valid is held during busy -> a single transaction only, resp_data=0; the second request is accepted after return to IDLE.
REQ-028 Reset pulsed during COLLECT of a wb-supplied read -> no resp_valid, memory unchanged, req_ready=1 immediately.
REQ-029 With SNOOP_TIMEOUT_EN, proc3 never responds -> resp_valid with resp_timeout=1 after 15 COLLECT cycles; without the macro, busy remains 1.
